// File: rtl/mole_link_pkg.sv
// Shared constants for the mole UART link: ASCII protocol bytes and drain FSM states.
package mole_link_pkg;

    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_H    = 8'h48;
    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } drain_state_e;

endpackage

// File: rtl/mole_link_fifo.sv
// Synchronous byte FIFO with registered occupancy count; storage is not reset, pointers are.
module mole_link_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_q[AW-1:0]];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Storage write port.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push_s) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop_s)  rd_q <= rd_q + (AW+1)'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mole_uart_link.sv
// UART protocol engine between game core and PC: event capture, byte arbiter, TX drain FSM, RX decode.
// Optional MOLE_LINK_HEARTBEAT_EN: resend the current mole index on every tick_1hz while running.
module mole_uart_link
    import mole_link_pkg::*;
#(
    parameter int NUM_MOLES  = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int HIT_CNT_W  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          game_active,
    input  logic                          game_finish,
    input  logic [NUM_MOLES-1:0]          mole_pos,
    input  logic                          hit_pulse,
    input  logic                          tick_1hz,
    input  logic                          tx_busy,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          rx_ready,
    input  logic [7:0]                    rx_data,
    output logic                          pc_start,
    output logic                          pc_hit,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [HIT_CNT_W-1:0] HIT_MAX = '1;

    function automatic logic is_onehot(input logic [NUM_MOLES-1:0] v);
        return (v != '0) && ((v & (v - NUM_MOLES'(1))) == '0);
    endfunction

    function automatic logic [3:0] onehot_idx(input logic [NUM_MOLES-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic                  pend_r_q, pend_r_d, r_sent_q, r_sent_d;
    logic                  pend_k_q, pend_k_d, pend_m_q, pend_m_d;
    logic [3:0]            m_idx_q, m_idx_d;
    logic [NUM_MOLES-1:0]  last_pos_q, last_pos_d;
    logic [HIT_CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic                  overflow_d;
    logic                  push_s, pop_s, deq_r_s, deq_k_s, deq_h_s, deq_m_s;
    logic [7:0]            push_data_s, fifo_head_s;
    logic                  fifo_full_s, fifo_empty_s;
    drain_state_e          state_q;

`ifndef MOLE_LINK_HEARTBEAT_EN
    logic unused_tick_s;
    assign unused_tick_s = tick_1hz;
`endif

    // Enqueue arbiter: one byte per cycle, priority R > K > H > mole.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = 8'd0;
        deq_r_s     = 1'b0;
        deq_k_s     = 1'b0;
        deq_h_s     = 1'b0;
        deq_m_s     = 1'b0;
        if (!fifo_full_s) begin
            if (pend_r_q) begin
                push_s = 1'b1; push_data_s = ASCII_R; deq_r_s = 1'b1;
            end else if (pend_k_q) begin
                push_s = 1'b1; push_data_s = ASCII_K; deq_k_s = 1'b1;
            end else if (hit_cnt_q != '0) begin
                push_s = 1'b1; push_data_s = ASCII_H; deq_h_s = 1'b1;
            end else if (pend_m_q) begin
                push_s = 1'b1; push_data_s = ASCII_ZERO + {4'd0, m_idx_q}; deq_m_s = 1'b1;
            end else begin
                push_s = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Pending-event capture; a capture in the same cycle as its dequeue keeps the event pending.
    always_comb begin
        pend_r_d   = pend_r_q && !deq_r_s;
        r_sent_d   = r_sent_q;
        pend_k_d   = (pend_k_q && !deq_k_s) || (rx_ready && (rx_data == ASCII_P));
        pend_m_d   = pend_m_q && !deq_m_s;
        m_idx_d    = m_idx_q;
        last_pos_d = last_pos_q;
        hit_cnt_d  = hit_cnt_q;
        overflow_d = overflow && !pc_start;

        if (game_finish && !r_sent_q) begin
            pend_r_d = 1'b1;
            r_sent_d = 1'b1;
        end else if (!game_active && !game_finish) begin
            r_sent_d = 1'b0;
        end else begin
            r_sent_d = r_sent_q;
        end

        case ({hit_pulse, deq_h_s})
            2'b10: begin
                if (hit_cnt_q == HIT_MAX) overflow_d = 1'b1;
                else hit_cnt_d = hit_cnt_q + HIT_CNT_W'(1);
            end
            2'b01:   hit_cnt_d = hit_cnt_q - HIT_CNT_W'(1);
            default: hit_cnt_d = hit_cnt_q;
        endcase

`ifdef MOLE_LINK_HEARTBEAT_EN
        if (tick_1hz && game_active && is_onehot(last_pos_q)) begin
            pend_m_d = 1'b1;
            m_idx_d  = onehot_idx(last_pos_q);
        end else begin
            m_idx_d  = m_idx_q;
        end
`endif

        if (game_active && (mole_pos != last_pos_q)) begin
            last_pos_d = mole_pos;
            if (is_onehot(mole_pos)) begin
                pend_m_d = 1'b1;
                m_idx_d  = onehot_idx(mole_pos);
            end else begin
                last_pos_d = mole_pos;
            end
        end else if (!game_active && !game_finish) begin
            last_pos_d = '0;
        end else begin
            last_pos_d = last_pos_q;
        end
    end

    // Pending state, RX command pulses and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_r_q   <= 1'b0;
            r_sent_q   <= 1'b0;
            pend_k_q   <= 1'b0;
            pend_m_q   <= 1'b0;
            m_idx_q    <= 4'd0;
            last_pos_q <= '0;
            hit_cnt_q  <= '0;
            overflow   <= 1'b0;
            pc_start   <= 1'b0;
            pc_hit     <= 1'b0;
        end else begin
            pend_r_q   <= pend_r_d;
            r_sent_q   <= r_sent_d;
            pend_k_q   <= pend_k_d;
            pend_m_q   <= pend_m_d;
            m_idx_q    <= m_idx_d;
            last_pos_q <= last_pos_d;
            hit_cnt_q  <= hit_cnt_d;
            overflow   <= overflow_d;
            pc_start   <= rx_ready && (rx_data == ASCII_S);
            pc_hit     <= rx_ready && (rx_data == ASCII_H) && game_active;
        end
    end

    assign pop_s = (state_q == IDLE) && !fifo_empty_s && !tx_busy;

    // Drain FSM; WAIT covers the cycle before uart_tx raises tx_busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        tx_start <= 1'b1;
                        tx_data  <= fifo_head_s;
                        state_q  <= SEND;
                    end else begin
                        tx_start <= 1'b0;
                    end
                end
                SEND: begin
                    tx_start <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    tx_start <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    mole_link_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_mole_uart_link.sv
// Scoreboard bench for mole_uart_link: a byte-queue reference model predicts every transmitted byte.
module tb_mole_uart_link;

    localparam int NM      = 5;
    localparam int DEPTH   = 8;
    localparam int HIT_MAX = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          game_active = 1'b0, game_finish = 1'b0;
    logic [NM-1:0] mole_pos = '0;
    logic          hit_pulse = 1'b0, tick_1hz = 1'b0, tx_busy = 1'b0;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          tx_start, pc_start, pc_hit, overflow;
    logic [7:0]    tx_data;
    logic [3:0]    fifo_count;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit         m_pend_r, m_r_sent, m_pend_k, m_pend_m, m_ovf, m_start, m_pc_start, m_pc_hit;
    int         m_hits, m_idx, m_cool;
    logic [NM-1:0] m_last;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];

    logic [7:0] tx_log[$];
    int         cycle = 0, last_start = 0, n_pc_start = 0, n_pc_hit = 0;
    bit         have_last = 0;
    logic [7:0] exp_b;

    mole_uart_link #(.NUM_MOLES(NM), .FIFO_DEPTH(DEPTH), .HIT_CNT_W(4)) dut (
        .clock(clock), .reset(reset), .game_active(game_active), .game_finish(game_finish),
        .mole_pos(mole_pos), .hit_pulse(hit_pulse), .tick_1hz(tick_1hz), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .rx_ready(rx_ready), .rx_data(rx_data),
        .pc_start(pc_start), .pc_hit(pc_hit), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name, input string exp);
        string act;
        act = "";
        foreach (tx_log[i]) act = $sformatf("%s%c", act, tx_log[i]);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_pend_r = 0; m_r_sent = 0; m_pend_k = 0; m_pend_m = 0; m_ovf = 0;
        m_start = 0; m_pc_start = 0; m_pc_hit = 0;
        m_hits = 0; m_idx = 0; m_cool = 0; m_last = '0;
        mq.delete(); exp_q.delete();
    endtask

    // One clock of protocol rules: drain, arbitrate, capture, all from pre-edge state.
    task automatic model_step();
        int         pre_size;
        bit         have_push, deq_r, deq_k, deq_h, deq_m;
        logic [7:0] pb;
        pre_size = mq.size();
        have_push = 0; deq_r = 0; deq_k = 0; deq_h = 0; deq_m = 0; pb = 8'd0;
        m_start = 0;
        if (m_cool > 0) m_cool--;
        else if (pre_size > 0 && !tx_busy) begin
            exp_q.push_back(mq.pop_front());
            m_start = 1;
            m_cool = 2;
        end
        if (pre_size < DEPTH) begin
            if (m_pend_r)        begin have_push = 1; pb = "R"; deq_r = 1; end
            else if (m_pend_k)   begin have_push = 1; pb = "K"; deq_k = 1; end
            else if (m_hits > 0) begin have_push = 1; pb = "H"; deq_h = 1; end
            else if (m_pend_m)   begin have_push = 1; pb = 8'(8'h30 + m_idx); deq_m = 1; end
        end
        if (deq_r) m_pend_r = 0;
        if (deq_k) m_pend_k = 0;
        if (deq_m) m_pend_m = 0;
        if (game_finish && !m_r_sent) begin m_pend_r = 1; m_r_sent = 1; end
        else if (!game_active && !game_finish) m_r_sent = 0;
        m_ovf = m_ovf && !m_pc_start;
        if (hit_pulse && m_hits == HIT_MAX && !deq_h) m_ovf = 1;
        else m_hits = m_hits + int'(hit_pulse) - int'(deq_h);
        if (rx_ready && rx_data == "P") m_pend_k = 1;
`ifdef MOLE_LINK_HEARTBEAT_EN
        if (tick_1hz && game_active && $countones(m_last) == 1) begin m_pend_m = 1; m_idx = $clog2(m_last); end
`endif
        if (game_active && mole_pos != m_last) begin
            m_last = mole_pos;
            if ($countones(mole_pos) == 1) begin m_pend_m = 1; m_idx = $clog2(mole_pos); end
        end else if (!game_active && !game_finish) m_last = '0;
        m_pc_start = rx_ready && rx_data == "S";
        m_pc_hit   = rx_ready && rx_data == "H" && game_active;
        if (have_push) mq.push_back(pb);
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_clear();
            else model_step();
        end
    end

    // Monitor: pops the scoreboard on every tx_start and compares status outputs each cycle.
    initial begin
        forever begin
            @(negedge clock);
            cycle++;
            if (!reset) have_last = 0;
            else begin
                chk("tx_start", tx_start, m_start);
                if (tx_start) begin
                    chk("tx_expected_avail", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        chk("tx_data", tx_data, exp_b);
                    end
                    tx_log.push_back(tx_data);
                    if (have_last) chk("tx_spacing_ge3", int'((cycle - last_start) >= 3), 1);
                    last_start = cycle;
                    have_last = 1;
                end
                chk("fifo_count", fifo_count, mq.size());
                chk("overflow", overflow, m_ovf);
                chk("pc_start", pc_start, m_pc_start);
                chk("pc_hit", pc_hit, m_pc_hit);
                if (pc_start) n_pc_start++;
                if (pc_hit) n_pc_hit++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_hit();
        hit_pulse = 1'b1; cyc(1); hit_pulse = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_ready = 1'b1; rx_data = b; cyc(1); rx_ready = 1'b0;
    endtask

    initial begin
        cyc(3);
        #1;
        chk("reset_tx_start", tx_start, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_pc_start", pc_start, 0);
        chk("reset_pc_hit", pc_hit, 0);
        cyc(1); #2 reset = 1'b1;
        cyc(2);

        // mole change 00001 -> 00100
        tx_log.delete();
        game_active = 1'b1; mole_pos = 5'b00001; cyc(1);
        mole_pos = 5'b00100; cyc(20);
        chk_log("mole_change_bytes", "02");

        // hits and a mole change queued behind a busy transmitter
        mole_pos = 5'b00000; cyc(2);
        tx_log.delete();
        tx_busy = 1'b1;
        pulse_hit(); cyc(1); pulse_hit(); cyc(1); pulse_hit(); cyc(1);
        mole_pos = 5'b00100; cyc(10);
        chk("busy_queue_count", fifo_count, 4);
        tx_busy = 1'b0; cyc(30);
        chk_log("busy_queue_bytes", "HHH2");

        // finish + hit together, long finish, then a second game
        tx_log.delete();
        mole_pos = 5'b00000;
        game_active = 1'b0; game_finish = 1'b1; hit_pulse = 1'b1; cyc(1);
        hit_pulse = 1'b0; cyc(99);
        game_finish = 1'b0; cyc(3);
        game_active = 1'b1; cyc(3);
        game_active = 1'b0; game_finish = 1'b1; cyc(10);
        game_finish = 1'b0; cyc(10);
        chk_log("finish_bytes", "RHR");

        // RX command decode
        tx_log.delete(); n_pc_start = 0; n_pc_hit = 0;
        game_active = 1'b1;
        send_rx("S"); cyc(2);
        send_rx("H"); cyc(2);
        send_rx("X"); cyc(2);
        game_active = 1'b0;
        send_rx("H"); cyc(2);
        send_rx("P"); cyc(10);
        chk("rx_pc_start_pulses", n_pc_start, 1);
        chk("rx_pc_hit_pulses", n_pc_hit, 1);
        chk_log("ping_reply", "K");

        // hit counter saturation and clear by pc_start
        tx_log.delete();
        game_active = 1'b1; tx_busy = 1'b1;
        hit_pulse = 1'b1; cyc(30); hit_pulse = 1'b0; cyc(2);
        chk("overflow_set", overflow, 1);
        send_rx("S"); cyc(2);
        chk("overflow_cleared", overflow, 0);
        tx_busy = 1'b0; cyc(120);
        chk("saturated_hit_bytes", tx_log.size(), 23);

        // reset with queued bytes
        tx_busy = 1'b1;
        repeat (5) begin pulse_hit(); cyc(1); end
        cyc(3);
        chk("queued_before_reset", fifo_count, 5);
        tx_busy = 1'b0; cyc(1);
        #2 reset = 1'b0;
        #1;
        chk("reset_mid_tx_start", tx_start, 0);
        chk("reset_mid_fifo_count", fifo_count, 0);
        cyc(3); #2 reset = 1'b1;
        cyc(2);
        tx_log.delete();
        game_active = 1'b1; mole_pos = 5'b00010; cyc(15);
        tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(15);
`ifdef MOLE_LINK_HEARTBEAT_EN
        chk_log("heartbeat_bytes", "11");
`else
        chk_log("heartbeat_bytes", "1");
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) begin
                case ($urandom_range(2))
                    0:       begin game_active = 1'b1; game_finish = 1'b0; end
                    1:       begin game_active = 1'b0; game_finish = 1'b1; end
                    default: begin game_active = 1'b0; game_finish = 1'b0; end
                endcase
            end
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(6))
                    0:       mole_pos = '0;
                    1:       mole_pos = NM'($urandom);
                    default: mole_pos = NM'(1) << $urandom_range(NM-1);
                endcase
            end
            if ($urandom_range(9) == 0) tx_busy = ~tx_busy;
            hit_pulse = ($urandom_range(5) == 0);
            tick_1hz  = ($urandom_range(39) == 0);
            rx_ready  = ($urandom_range(9) == 0);
            case ($urandom_range(3))
                0:       rx_data = "S";
                1:       rx_data = "H";
                2:       rx_data = "P";
                default: rx_data = 8'($urandom);
            endcase
            cyc(1);
        end
        hit_pulse = 1'b0; tick_1hz = 1'b0; rx_ready = 1'b0; tx_busy = 1'b0;
        game_active = 1'b0; game_finish = 1'b0;
        cyc(200);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_fifo_empty", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
